arf_controller: RTL and testbench
=================================

# arf_controller

Sequencing controller for the three-register address register file (PC, SP, AR). It accepts one command at a time over a valid/ready handshake. For each command it drives the register file's RegSel, FunSel, OutDSel and data input in the correct cycle order, and strobes memory in the cycle OutD carries the address. It also initialises PC/AR/SP after reset and guards stack depth.

## Interface
- SP_INIT, 16'hFFFF: SP value loaded during post-reset init.
- STACK_DEPTH, 256: max number of outstanding pushes.
- DEPTH_W, 9: width of sp_depth; must hold STACK_DEPTH.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle; command accepted on edge where valid&&ready.
- cmd_op  in  3  000 FETCH, 001 PUSH, 010 POP, 011 JUMP, 100 LDAR, 101 RDAR, 110 WRAR, 111 reserved.
- cmd_data  in  16  load value for JUMP/LDAR.
- alu_csel  in  2  OutC source request, registered into OutCSel every cycle.
- done  out  1  one-cycle pulse in final cycle of a command.
- err  out  1  one-cycle pulse, coincident with done, for rejected commands.
- mem_re / mem_we  out  1 each  memory read/write strobe; address is register file OutD in that cycle.
- RegSel  out  3  bit0 PC, bit1 SP, bit2 AR enables.
- FunSel  out  2  00 decrement, 01 increment, 10 load, 11 clear.
- OutCSel, OutDSel  out  2 each  00 PC, 01 SP, 10 AR.
- arf_i  out  32  register file data input, {16'b0, value}.
- sp_depth  out  DEPTH_W  current stack occupancy.

## Operation
- All outputs registered. Register file output mux is registered, so OutD reflects OutDSel one cycle after it is driven. SP changes take effect one edge after enable, so select must follow any SP update by one cycle.
- States: INIT0, INIT1, IDLE, S1, S2, S3.
- INIT0: RegSel=111, FunSel=11 (clear all).
- INIT1: RegSel=010, FunSel=10, arf_i=SP_INIT.
- INIT1 also clears sp_depth, then goes to IDLE.
- cmd_ready=1 only in IDLE. Outside listed cycles RegSel=000, mem_re=mem_we=0, and OutDSel holds its last value.
- Command sequences, starting at S1 after the accept edge:
  - FETCH: S1 OutDSel=00. S2 mem_re. S3 RegSel=001, FunSel=01, done.
  - PUSH: S1 RegSel=010, FunSel=00. S2 OutDSel=01. S3 mem_we, done, sp_depth+1.
  - POP: S1 OutDSel=01. S2 mem_re. S3 RegSel=010, FunSel=01, done, sp_depth-1.
  - JUMP / LDAR: S1 RegSel=001 / 100, FunSel=10, arf_i={16'b0,cmd_data}, done.
  - RDAR / WRAR: S1 OutDSel=10. S2 mem_re / mem_we, done.
- Rejects cause no register file enable and no memory strobe, with done+err in S1:
  - PUSH when sp_depth==STACK_DEPTH.
  - POP when sp_depth==0.
  - op 111.
- sp_depth is unaffected by JUMP/LDAR and never wraps.
- SP arithmetic wraps mod 2^16 inside the register file; the controller does not check it.

## Timing
- Reset asserted on any edge: next cycle all outputs 0 (RegSel=000, FunSel=00, OutCSel=OutDSel=00, arf_i=0, strobes/done/err=0, cmd_ready=0, sp_depth=0).
- State goes to INIT0; an in-flight command is abandoned, with no done.
- First cmd_ready=1 is the third cycle after reset deasserts.
- Latency accept→done:
  - FETCH/PUSH/POP: 3 cycles.
  - RDAR/WRAR: 2 cycles.
  - JUMP/LDAR/reject: 1 cycle.
- cmd_ready returns the cycle after done, giving one-cycle IDLE minimum between commands.
- Back-to-back FETCH throughput is 1 per 4 cycles.
- cmd_op/cmd_data are sampled only on the accept edge; later changes are ignored.
- cmd_valid while busy is ignored; the requester holds it until ready.
- OutCSel = alu_csel delayed one cycle, independent of state.

## Test plan
- Reset then idle:
  - Stimulus: reset held, then released.
  - Expect INIT0 RegSel=111/FunSel=11, then INIT1 RegSel=010/FunSel=10/arf_i=0x0000FFFF.
  - Expect cmd_ready at cycle 3 and sp_depth=0.
- JUMP then FETCH:
  - Stimulus: JUMP 0x0040, then FETCH.
  - Expect PC load with arf_i=0x00000040.
  - FETCH: OutDSel=00, mem_re next cycle (model OutD=0x0040), then PC increment, done; model PC=0x0041.
- PUSH, POP:
  - PUSH from SP=0xFFFF: SP dec, OutDSel=01, mem_we with OutD=0xFFFE, sp_depth=1.
  - POP: mem_re with OutD=0xFFFE, SP inc to 0xFFFF, sp_depth=0.
- Stack guards:
  - POP at depth 0 → done+err at S1, no strobe, no RegSel.
  - 256 PUSHes then PUSH → err, sp_depth stays 256.
- LDAR 0x1234, RDAR, WRAR: AR loaded; mem_re then mem_we, each with model OutD=0x1234, 2-cycle latency each.
- Reset during PUSH S2:
  - No mem_we, no done, SP not re-selected.
  - INIT sequence replays; sp_depth=0.
  - Reserved op 111 → err after 1 cycle.

Source files
------------

// File: rtl/arf_controller.sv
// arf_controller
// ---------------------------------------------------------------------------
// Sequencing controller for the PC / SP / AR address register file. It takes
// one command at a time over a valid/ready handshake and, for each command,
// drives the register-file controls in the order the register file needs:
// enables first, output select next, memory strobe once OutD carries the
// address. After reset it clears all three registers, loads SP with SP_INIT,
// and it refuses pushes and pops that would overflow or underflow the stack.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   cmd_valid  in   command offered
//   cmd_ready  out  controller idle; accept on edge where valid && ready
//   cmd_op     in   000 FETCH, 001 PUSH, 010 POP, 011 JUMP,
//                   100 LDAR, 101 RDAR, 110 WRAR, 111 reserved
//   cmd_data   in   load value for JUMP / LDAR
//   alu_csel   in   OutC source request, re-registered as OutCSel
//   done       out  one-cycle pulse in the final cycle of a command
//   err        out  one-cycle pulse with done for a rejected command
//   mem_re     out  memory read strobe (address = register file OutD)
//   mem_we     out  memory write strobe (address = register file OutD)
//   RegSel     out  enables: bit0 PC, bit1 SP, bit2 AR
//   FunSel     out  00 dec, 01 inc, 10 load, 11 clear
//   OutCSel    out  register file OutC select (00 PC, 01 SP, 10 AR)
//   OutDSel    out  register file OutD select (00 PC, 01 SP, 10 AR)
//   arf_i      out  register file data input, {16'b0, value}
//   sp_depth   out  current stack occupancy
// ---------------------------------------------------------------------------
module arf_controller #(
    parameter logic [15:0] SP_INIT     = 16'hFFFF,
    parameter int          STACK_DEPTH = 256,
    parameter int          DEPTH_W     = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [15:0]        cmd_data,
    input  logic [1:0]         alu_csel,
    output logic               done,
    output logic               err,
    output logic               mem_re,
    output logic               mem_we,
    output logic [2:0]         RegSel,
    output logic [1:0]         FunSel,
    output logic [1:0]         OutCSel,
    output logic [1:0]         OutDSel,
    output logic [31:0]        arf_i,
    output logic [DEPTH_W-1:0] sp_depth
);

    localparam logic [2:0] OP_FETCH = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_JUMP  = 3'b011;
    localparam logic [2:0] OP_LDAR  = 3'b100;
    localparam logic [2:0] OP_RDAR  = 3'b101;
    localparam logic [2:0] OP_WRAR  = 3'b110;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    // The state names the phase that the coming clock edge will issue onto
    // the registered outputs. The first command phase (S1) is issued by the
    // accept edge itself, straight out of IDLE, so only S2 and S3 need to be
    // remembered between edges.
    typedef enum logic [2:0] {
        INIT0,
        INIT1,
        IDLE,
        S2,
        S3
    } state_t;

    state_t     state;
    logic [2:0] op;

    // Single registered FSM. Every edge first returns the pulses and enables
    // to their idle values, then the current state overrides the outputs of
    // the phase it issues. FunSel and arf_i are left holding because they
    // are meaningless while RegSel is 000, and OutDSel must hold so the
    // register file keeps presenting the last selected address.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT0;
            op        <= 3'b000;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            RegSel    <= 3'b000;
            FunSel    <= 2'b00;
            OutCSel   <= 2'b00;
            OutDSel   <= 2'b00;
            arf_i     <= 32'h0;
            sp_depth  <= '0;
        end else begin
            OutCSel <= alu_csel;
            RegSel  <= 3'b000;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;

            case (state)
                INIT0: begin
                    RegSel <= 3'b111;
                    FunSel <= 2'b11;
                    state  <= INIT1;
                end

                INIT1: begin
                    RegSel   <= 3'b010;
                    FunSel   <= 2'b10;
                    arf_i    <= {16'h0, SP_INIT};
                    sp_depth <= '0;
                    state    <= IDLE;
                end

                // IDLE first raises cmd_ready for a cycle, which gives the
                // one-cycle idle gap between commands; an accept then issues
                // the S1 controls directly. Single-cycle commands stay in
                // IDLE, where the next edge raises cmd_ready again.
                IDLE: begin
                    if (!cmd_ready) begin
                        cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        op        <= cmd_op;
                        case (cmd_op)
                            OP_FETCH: begin
                                OutDSel <= 2'b00;
                                state   <= S2;
                            end
                            OP_PUSH: begin
                                if (sp_depth == DEPTH_FULL) begin
                                    done <= 1'b1;
                                    err  <= 1'b1;
                                end else begin
                                    RegSel <= 3'b010;
                                    FunSel <= 2'b00;
                                    state  <= S2;
                                end
                            end
                            OP_POP: begin
                                if (sp_depth == '0) begin
                                    done <= 1'b1;
                                    err  <= 1'b1;
                                end else begin
                                    OutDSel <= 2'b01;
                                    state   <= S2;
                                end
                            end
                            OP_JUMP: begin
                                RegSel <= 3'b001;
                                FunSel <= 2'b10;
                                arf_i  <= {16'h0, cmd_data};
                                done   <= 1'b1;
                            end
                            OP_LDAR: begin
                                RegSel <= 3'b100;
                                FunSel <= 2'b10;
                                arf_i  <= {16'h0, cmd_data};
                                done   <= 1'b1;
                            end
                            OP_RDAR, OP_WRAR: begin
                                OutDSel <= 2'b10;
                                state   <= S2;
                            end
                            default: begin
                                done <= 1'b1;
                                err  <= 1'b1;
                            end
                        endcase
                    end
                end

                // PUSH selects SP only now, one cycle after its decrement
                // was enabled, so OutD shows the decremented address in S3.
                S2: begin
                    state <= S3;
                    case (op)
                        OP_FETCH: mem_re  <= 1'b1;
                        OP_PUSH:  OutDSel <= 2'b01;
                        OP_POP:   mem_re  <= 1'b1;
                        OP_RDAR: begin
                            mem_re <= 1'b1;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end
                        OP_WRAR: begin
                            mem_we <= 1'b1;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end

                S3: begin
                    state <= IDLE;
                    case (op)
                        OP_FETCH: begin
                            RegSel <= 3'b001;
                            FunSel <= 2'b01;
                            done   <= 1'b1;
                        end
                        OP_PUSH: begin
                            mem_we   <= 1'b1;
                            done     <= 1'b1;
                            sp_depth <= sp_depth + 1'b1;
                        end
                        OP_POP: begin
                            RegSel   <= 3'b010;
                            FunSel   <= 2'b01;
                            done     <= 1'b1;
                            sp_depth <= sp_depth - 1'b1;
                        end
                        default: ;
                    endcase
                end

                default: state <= INIT0;
            endcase
        end
    end

endmodule

// File: tb/tb_arf_controller.sv
// tb_arf_controller
// ---------------------------------------------------------------------------
// Directed bench for arf_controller. A small register-file model (PC, SP, AR
// and a registered OutD mux) follows the controller's outputs so that the
// address presented during each memory strobe can be compared against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_arf_controller;

    localparam int DEPTH_W = 9;

    logic               clock     = 1'b0;
    logic               reset     = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [2:0]         cmd_op    = 3'b000;
    logic [15:0]        cmd_data  = 16'h0;
    logic [1:0]         alu_csel  = 2'b00;
    logic               done;
    logic               err;
    logic               mem_re;
    logic               mem_we;
    logic [2:0]         RegSel;
    logic [1:0]         FunSel;
    logic [1:0]         OutCSel;
    logic [1:0]         OutDSel;
    logic [31:0]        arf_i;
    logic [DEPTH_W-1:0] sp_depth;

    int assertCount = 0;
    int failCount   = 0;

    logic [15:0] mPc;
    logic [15:0] mSp;
    logic [15:0] mAr;
    logic [15:0] outD;

    arf_controller #(
        .SP_INIT     (16'hFFFF),
        .STACK_DEPTH (256),
        .DEPTH_W     (DEPTH_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_csel  (alu_csel),
        .done      (done),
        .err       (err),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .RegSel    (RegSel),
        .FunSel    (FunSel),
        .OutCSel   (OutCSel),
        .OutDSel   (OutDSel),
        .arf_i     (arf_i),
        .sp_depth  (sp_depth)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] applyFun(input logic [15:0] v, input logic [1:0] f,
                                             input logic [15:0] ld);
        case (f)
            2'b00:   return v - 16'h1;
            2'b01:   return v + 16'h1;
            2'b10:   return ld;
            default: return 16'h0;
        endcase
    endfunction

    // Register file model: enabled registers update on the edge after the
    // controls are issued, and OutD registers the selected register.
    always @(posedge clock) begin
        if (RegSel[0] === 1'b1) mPc <= applyFun(mPc, FunSel, arf_i[15:0]);
        if (RegSel[1] === 1'b1) mSp <= applyFun(mSp, FunSel, arf_i[15:0]);
        if (RegSel[2] === 1'b1) mAr <= applyFun(mAr, FunSel, arf_i[15:0]);
        case (OutDSel)
            2'b00:   outD <= mPc;
            2'b01:   outD <= mSp;
            2'b10:   outD <= mAr;
            default: outD <= 16'h0;
        endcase
    end

    // Controls that must be idle outside their listed cycles, packed as
    // {RegSel, mem_re, mem_we, done, err}.
    function automatic logic [31:0] ctlObs();
        return {25'b0, RegSel, mem_re, mem_we, done, err};
    endfunction

    function automatic logic [31:0] cx(input logic [2:0] rs, input logic re, input logic we,
                                       input logic dn, input logic er);
        return {25'b0, rs, re, we, dn, er};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for cmd_ready, offers one command for exactly the
    // accept edge, then scrambles op/data. Returns in the S1 cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] data);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checkOutput("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_data  = ~data;
    endtask

    initial begin
        // Reset held, then the init sequence.
        reset = 1'b1;
        repeat (3) step();
        checkOutput("reset_outputs",
                    {18'b0, cmd_ready, RegSel, FunSel, OutCSel, OutDSel, mem_re, mem_we, done, err}, 32'h0);
        checkOutput("reset_arf_i", arf_i, 32'h0);
        checkOutput("reset_depth", sp_depth, 32'h0);
        reset = 1'b0;
        step();
        checkOutput("init0_ctl", ctlObs(), cx(3'b111, 0, 0, 0, 0));
        checkOutput("init0_fun", FunSel, 2'b11);
        checkOutput("init0_ready", cmd_ready, 1'b0);
        step();
        checkOutput("init1_ctl", ctlObs(), cx(3'b010, 0, 0, 0, 0));
        checkOutput("init1_fun", FunSel, 2'b10);
        checkOutput("init1_arf_i", arf_i, 32'h0000FFFF);
        checkOutput("init1_ready", cmd_ready, 1'b0);
        step();
        checkOutput("cycle3_ready", cmd_ready, 1'b1);
        checkOutput("cycle3_depth", sp_depth, 32'h0);
        checkOutput("cycle3_ctl", ctlObs(), cx(3'b000, 0, 0, 0, 0));
        checkOutput("init_model_sp", mSp, 16'hFFFF);
        checkOutput("init_model_pc", mPc, 16'h0000);

        // OutCSel follows alu_csel one cycle late.
        alu_csel = 2'b10;
        step();
        checkOutput("outcsel_a", OutCSel, 2'b10);
        alu_csel = 2'b01;
        step();
        checkOutput("outcsel_b", OutCSel, 2'b01);
        alu_csel = 2'b00;

        // JUMP 0x0040
        applyStimulus(3'b011, 16'h0040);
        checkOutput("jump_ctl", ctlObs(), cx(3'b001, 0, 0, 1, 0));
        checkOutput("jump_fun", FunSel, 2'b10);
        checkOutput("jump_arf_i", arf_i, 32'h00000040);
        step();
        checkOutput("jump_after_ctl", ctlObs(), cx(3'b000, 0, 0, 0, 0));
        checkOutput("jump_after_ready", cmd_ready, 1'b1);
        checkOutput("jump_model_pc", mPc, 16'h0040);

        // FETCH
        applyStimulus(3'b000, 16'hBEEF);
        checkOutput("fetch_s1_sel", OutDSel, 2'b00);
        checkOutput("fetch_s1_ctl", ctlObs(), cx(3'b000, 0, 0, 0, 0));
        step();
        checkOutput("fetch_s2_ctl", ctlObs(), cx(3'b000, 1, 0, 0, 0));
        checkOutput("fetch_s2_outd", outD, 16'h0040);
        step();
        checkOutput("fetch_s3_ctl", ctlObs(), cx(3'b001, 0, 0, 1, 0));
        checkOutput("fetch_s3_fun", FunSel, 2'b01);
        step();
        checkOutput("fetch_after_ready", cmd_ready, 1'b1);
        checkOutput("fetch_model_pc", mPc, 16'h0041);

        // PUSH from SP=0xFFFF
        applyStimulus(3'b001, 16'h0);
        checkOutput("push_s1_ctl", ctlObs(), cx(3'b010, 0, 0, 0, 0));
        checkOutput("push_s1_fun", FunSel, 2'b00);
        step();
        checkOutput("push_s2_sel", OutDSel, 2'b01);
        checkOutput("push_s2_ctl", ctlObs(), cx(3'b000, 0, 0, 0, 0));
        checkOutput("push_s2_model_sp", mSp, 16'hFFFE);
        step();
        checkOutput("push_s3_ctl", ctlObs(), cx(3'b000, 0, 1, 1, 0));
        checkOutput("push_s3_outd", outD, 16'hFFFE);
        checkOutput("push_s3_depth", sp_depth, 32'd1);
        step();

        // POP
        applyStimulus(3'b010, 16'h0);
        checkOutput("pop_s1_sel", OutDSel, 2'b01);
        checkOutput("pop_s1_ctl", ctlObs(), cx(3'b000, 0, 0, 0, 0));
        step();
        checkOutput("pop_s2_ctl", ctlObs(), cx(3'b000, 1, 0, 0, 0));
        checkOutput("pop_s2_outd", outD, 16'hFFFE);
        step();
        checkOutput("pop_s3_ctl", ctlObs(), cx(3'b010, 0, 0, 1, 0));
        checkOutput("pop_s3_fun", FunSel, 2'b01);
        checkOutput("pop_s3_depth", sp_depth, 32'd0);
        step();
        checkOutput("pop_model_sp", mSp, 16'hFFFF);

        // POP at depth 0 is rejected.
        applyStimulus(3'b010, 16'h0);
        checkOutput("pop_empty_ctl", ctlObs(), cx(3'b000, 0, 0, 1, 1));
        step();
        checkOutput("pop_empty_after", ctlObs(), cx(3'b000, 0, 0, 0, 0));
        checkOutput("pop_empty_depth", sp_depth, 32'd0);
        checkOutput("pop_empty_sel_hold", OutDSel, 2'b01);

        // Fill the stack, then one more PUSH is rejected.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(3'b001, 16'h0);
            step();
            step();
        end
        step();
        checkOutput("full_depth", sp_depth, 32'd256);
        checkOutput("full_model_sp", mSp, 16'hFEFF);
        applyStimulus(3'b001, 16'h0);
        checkOutput("push_full_ctl", ctlObs(), cx(3'b000, 0, 0, 1, 1));
        step();
        checkOutput("push_full_depth", sp_depth, 32'd256);
        checkOutput("push_full_model_sp", mSp, 16'hFEFF);

        // LDAR, RDAR, WRAR
        applyStimulus(3'b100, 16'h1234);
        checkOutput("ldar_ctl", ctlObs(), cx(3'b100, 0, 0, 1, 0));
        checkOutput("ldar_fun", FunSel, 2'b10);
        checkOutput("ldar_arf_i", arf_i, 32'h00001234);
        step();
        checkOutput("ldar_model_ar", mAr, 16'h1234);
        checkOutput("ldar_depth", sp_depth, 32'd256);
        applyStimulus(3'b101, 16'h0);
        checkOutput("rdar_s1_sel", OutDSel, 2'b10);
        checkOutput("rdar_s1_ctl", ctlObs(), cx(3'b000, 0, 0, 0, 0));
        step();
        checkOutput("rdar_s2_ctl", ctlObs(), cx(3'b000, 1, 0, 1, 0));
        checkOutput("rdar_s2_outd", outD, 16'h1234);
        step();
        applyStimulus(3'b110, 16'h0);
        checkOutput("wrar_s1_sel", OutDSel, 2'b10);
        step();
        checkOutput("wrar_s2_ctl", ctlObs(), cx(3'b000, 0, 1, 1, 0));
        checkOutput("wrar_s2_outd", outD, 16'h1234);
        step();

        // Make room, then reset in the middle of a PUSH.
        applyStimulus(3'b010, 16'h0);
        step();
        step();
        step();
        checkOutput("pop_room_depth", sp_depth, 32'd255);
        applyStimulus(3'b001, 16'h0);
        step();
        checkOutput("abort_s2_sel", OutDSel, 2'b01);
        reset = 1'b1;
        step();
        checkOutput("abort_outputs",
                    {18'b0, cmd_ready, RegSel, FunSel, OutCSel, OutDSel, mem_re, mem_we, done, err}, 32'h0);
        checkOutput("abort_depth", sp_depth, 32'd0);
        reset = 1'b0;
        step();
        checkOutput("reinit0_ctl", ctlObs(), cx(3'b111, 0, 0, 0, 0));
        step();
        checkOutput("reinit1_ctl", ctlObs(), cx(3'b010, 0, 0, 0, 0));
        checkOutput("reinit1_arf_i", arf_i, 32'h0000FFFF);
        step();
        checkOutput("reinit_ready", cmd_ready, 1'b1);
        checkOutput("reinit_depth", sp_depth, 32'd0);
        checkOutput("reinit_model_sp", mSp, 16'hFFFF);

        // Reserved opcode
        applyStimulus(3'b111, 16'h0);
        checkOutput("reserved_ctl", ctlObs(), cx(3'b000, 0, 0, 1, 1));
        step();
        checkOutput("reserved_after_ready", cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
